// File: rtl/instr_word_loader.sv
// Packs decoded instruction fields into 32-bit MIPS words and streams them into instruction memory.
// Optional build macro ILLEGAL_OP_NOP_EN: illegal opcodes write a NOP instead of being dropped.
module instr_word_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] enc;
    logic        legal;
    logic        accept;
    logic        do_write;
    logic        at_top;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (in_op)
            6'b000000: enc = {in_op, in_rs, in_rt, in_rd, in_shamt, in_funct};
            6'b100011, 6'b101011, 6'b000100, 6'b000101: enc = {in_op, in_rs, in_rt, in_imm};
            6'b000010: enc = {in_op, in_target};
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    assign accept = in_valid && (state_q == StLoad);
`ifdef ILLEGAL_OP_NOP_EN
    assign do_write = accept;
`else
    assign do_write = accept && legal;
`endif
    assign at_top = (ptr_q == {ADDR_W{1'b1}});

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wc_d    = wc_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    wc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (!legal) err_d = 1'b1;
                    if (do_write) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc;
                        wc_d    = wc_q + 1'b1;
                        // Pointer saturates at the top; the load ends there anyway.
                        if (!at_top) ptr_d = ptr_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = StDone;
                    end else if (do_write && at_top) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            wc_q    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == StLoad);
    assign cpu_hold   = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign word_count = wc_q;

endmodule

// File: doc/instr_word_loader.md
Name: instr_word_loader

Overview:
- Encoder and writer side of the opcode interface used by the single-cycle datapath.
- Accepts decoded instruction fields over a valid/ready stream and packs each into a 32-bit MIPS word (R, I or J format) for the six opcodes the core's control decodes.
- Writes the packed words sequentially into instruction memory and holds the CPU while a load is in progress.
- Sits between the testbench/host program source and the instruction memory write port.

Parameters:
ADDR_W, 8, instruction memory word-address width; memory depth is 2**ADDR_W words.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a load; sampled only in IDLE
in_valid  in  1  field bundle valid
in_ready  out  1  loader can accept a bundle
in_op  in  6  opcode
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R only)
in_shamt  in  5  shamt (R only)
in_funct  in  6  funct (R only)
in_imm  in  16  immediate (I only)
in_target  in  26  jump target (J only)
in_last  in  1  final bundle of the program
im_we  out  1  instruction memory write enable
im_addr  out  ADDR_W  word address
im_wdata  out  32  encoded instruction word
cpu_hold  out  1  keep core stalled/in reset
done  out  1  one-cycle pulse, load finished
err  out  1  sticky error for the current load
word_count  out  ADDR_W+1  words written in the current load

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0, err=0, word_count=0.
- Reset mid-load aborts the load immediately. No write is issued in the reset cycle. Words already written stay in memory.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD. On that transition, clear the write pointer, word_count and err.
  - LOAD: in_ready=1 (combinational from state). A bundle is accepted when in_valid && in_ready.
  - DONE: lasts exactly 1 cycle with done=1, then -> IDLE.
- start is ignored while in LOAD or DONE.
- cpu_hold=1 whenever state is not IDLE.
- Encoding, registered with 1-cycle latency (bundle accepted at edge N, so im_we=1 with im_addr/im_wdata valid during cycle N+1):
  - in_op=000000 (R type): {op, rs, rt, rd, shamt, funct}.
  - in_op=100011 (LW), 101011 (SW), 000100 (BEQ) or 000101 (BNE): {op, rs, rt, imm}.
  - in_op=000010 (J): {op, target}.
  - Any other opcode is illegal: err is set and the bundle is handled per the Optional Feature.
- Write pointer and counter:
  - im_addr is the write pointer value at accept time.
  - The pointer increments by 1 per written word; word_count increments in the same cycle as im_we.
- Completion: an accepted bundle with in_last=1 -> DONE on the next cycle. The done pulse coincides with the final im_we (if any).
- Full boundary: an accepted write to address 2**ADDR_W-1 with in_last=0 -> DONE, with err=1 (overflow).
  - The pointer does not wrap.
  - in_ready=0 in DONE, so no further bundle is accepted.
- Illegal opcode with in_last=1: still -> DONE, err=1.
- im_we is a single-cycle pulse per word. im_wdata/im_addr hold their last values when im_we=0.
- Backpressure: in_valid may drop between bundles with no effect. Fields are sampled only on accept.

Optional Feature:
- Macro: ILLEGAL_OP_NOP_EN.
- Defined: an illegal opcode writes 32'h00000000 (NOP) at the current address. The pointer and word_count advance; err=1.
- Not defined: an illegal opcode is dropped. No im_we, pointer and word_count unchanged; err=1.

Test Plan:
- start; R bundle rs=1, rt=2, rd=3, shamt=0, funct=0x20, last=1 -> next cycle im_we=1, im_addr=0, im_wdata=32'h00221820, done=1, err=0, word_count=1; cpu_hold falls the cycle after.
- Stream LW rs=9 rt=8 imm=4; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x10 (last) -> writes 0x8D280004 @0, 0x1022FFFF @1, 0x08000010 @2; word_count=3.
- ADDR_W=2, 5 bundles all last=0 -> 4 writes at addr 0..3, DONE after the 4th write, err=1, word_count=4, fifth bundle never accepted (in_ready=0).
- Illegal op 6'b001000 between two legal words -> without macro: writes at addr 0,1 only, err=1. With ILLEGAL_OP_NOP_EN: 32'h0 at addr 1, second legal word at addr 2, err=1.
- rst=1 during LOAD after 2 writes -> next cycle all outputs at reset values, no im_we. A new start loads again from addr 0 with err=0.
- start pulsed during LOAD; in_valid toggling 1/0 -> start has no effect, exactly one write per accepted bundle, addresses contiguous.
